spi_master_byte: RTL and testbench

//  Byte-level SPI master engine: the responder on the spitx/spitxdv/spitxready/spirx/spirxdv

---
 rtl/spi_master_byte.sv | 155 +++++++++++++++
 tb/tb_spi_master_byte.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_byte.sv
// Byte-level SPI master: shifts one byte out on mosi MSB-first while capturing miso, with sclk derived from clk.
// Optional build macro SPI_MISO_SYNC_EN adds a 2-flop miso synchronizer with matching capture delay.
module spi_master_byte #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spitx,
  input  logic       spitxdv,
  output logic       spitxready,
  output logic [7:0] spirx,
  output logic       spirxdv,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic       CPOL = (SPI_MODE >= 2);
  localparam logic       CPHA = ((SPI_MODE % 2) == 1);
  localparam logic [7:0] TMAX = 8'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic [4:0] next_edge;
  logic       edge_q, edge_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] spirx_q, spirx_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       rdy_q, rdy_d;
  logic       rxdv_q, rxdv_d;
  logic       accept, wrap, samp_now, cap_en, cap_bit, cap_pending;

  // edge_q marks the cycle in which sclk first shows a new level; sampling happens then.
  assign samp_now = edge_q && (state_q == SHIFT) &&
                    (CPHA ? (!edge_cnt_q[0] && (edge_cnt_q != 5'd0)) : edge_cnt_q[0]);

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_q;
  logic [1:0] samp_pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_sync_q <= '0;
      samp_pipe_q <= '0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], miso};
      samp_pipe_q <= {samp_pipe_q[0], samp_now};
    end
  end

  // Capture strobe trails the sampling edge by the synchronizer depth; hold off DONE until it lands.
  assign cap_en      = samp_pipe_q[1];
  assign cap_bit     = miso_sync_q[1];
  assign cap_pending = samp_now | samp_pipe_q[0];
`else
  assign cap_en      = samp_now;
  assign cap_bit     = miso;
  assign cap_pending = 1'b0;
`endif

  assign accept = spitxdv && rdy_q;
  assign wrap   = (timer_q == TMAX);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    edge_d     = 1'b0;
    tx_d       = tx_q;
    rx_d       = rx_q;
    spirx_d    = spirx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    next_edge  = edge_cnt_q + 5'd1;

    if (cap_en) rx_d = {rx_q[6:0], cap_bit};

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          // The accept cycle counts as the first timer tick so edge k lands at T+k*N.
          state_d    = SHIFT;
          timer_d    = 8'd1;
          edge_cnt_d = '0;
          tx_d       = spitx;
          if (!CPHA) mosi_d = spitx[7];
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        timer_d = wrap ? '0 : timer_q + 8'd1;
        if (wrap && (edge_cnt_q != 5'd16)) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = next_edge;
          edge_d     = 1'b1;
          if (CPHA ? next_edge[0] : (!next_edge[0] && (next_edge <= 5'd14))) begin
            mosi_d = CPHA ? tx_q[7] : tx_q[6];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        if ((edge_cnt_q == 5'd16) && !cap_pending) begin
          state_d = DONE;
          timer_d = '0;
          spirx_d = rx_d;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d  = (state_d != SHIFT);
    rxdv_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      edge_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      spirx_q    <= '0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      rdy_q      <= 1'b1;
      rxdv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      spirx_q    <= spirx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rdy_q      <= rdy_d;
      rxdv_q     <= rxdv_d;
    end
  end

  assign spitxready = rdy_q;
  assign spirx      = spirx_q;
  assign spirxdv    = rxdv_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Self-checking bench for spi_master_byte: four instances (SPI modes 0..3) each talking to a
// behavioural SPI slave that returns a chosen byte and collects the mosi byte at its own sampling edges.
module tb_spi_master_byte;

`ifdef SPI_MISO_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int N0 = (SYNC != 0) ? 3 : 2;

  logic       clk, rst;
  logic [7:0] spitx_a   [4];
  logic       spitxdv_a [4];
  logic       spitxready_a [4];
  logic [7:0] spirx_a   [4];
  logic       spirxdv_a [4];
  logic       sclk_a    [4];
  logic       mosi_a    [4];
  logic       miso_a    [4];

  logic [7:0] slv_byte  [4];
  logic [7:0] mosi_rx   [4];
  logic       prev_s    [4];
  int         ecnt      [4];
  int         tot_edges [4];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_byte #(
      .SPI_MODE         (g),
      .CLKS_PER_HALF_BIT((g == 1) ? 3 : (g == 3) ? 4 : N0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .spitx     (spitx_a[g]),
      .spitxdv   (spitxdv_a[g]),
      .spitxready(spitxready_a[g]),
      .spirx     (spirx_a[g]),
      .spirxdv   (spirxdv_a[g]),
      .sclk      (sclk_a[g]),
      .mosi      (mosi_a[g]),
      .miso      (miso_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input int g);
    return (g == 1) ? 3 : (g == 3) ? 4 : N0;
  endfunction

  function automatic int lat_of(input int g);
    return 16 * n_of(g) + 1 + (((SYNC != 0) && ((g % 2) == 1)) ? 2 : 0);
  endfunction

  // Slave: counts sclk edges, samples mosi on its sampling edges, presents miso MSB-first.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int idx;
      if (rst) begin
        ecnt[i]   = 0;
        prev_s[i] = (i >= 2);
      end else if (sclk_a[i] !== prev_s[i]) begin
        prev_s[i]    = sclk_a[i];
        ecnt[i]      = (ecnt[i] % 16) + 1;
        tot_edges[i] = tot_edges[i] + 1;
        if (((i % 2) == 1) ? ((ecnt[i] % 2) == 0) : ((ecnt[i] % 2) == 1))
          mosi_rx[i] = {mosi_rx[i][6:0], mosi_a[i]};
      end
      if ((i % 2) == 1) idx = (ecnt[i] == 0) ? 0 : (ecnt[i] - 1) / 2;
      else              idx = (ecnt[i] % 16) / 2;
      miso_a[i] = slv_byte[i][7 - idx];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  task automatic run_xfer(input int g, input logic [7:0] tx, input logic [7:0] sb, input int inj,
                          output int lat, output logic [7:0] rx, output logic [7:0] mo,
                          output int edges, output logic mosi_hi);
    int e0, w;
    w = 0;
    @(negedge clk);
    while ((spitxready_a[g] !== 1'b1) && (w < 300)) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", spitxready_a[g], 1);
    slv_byte[g]  = sb;
    spitx_a[g]   = tx;
    spitxdv_a[g] = 1'b1;
    e0      = tot_edges[g];
    mosi_hi = 1'b0;
    lat     = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) spitxdv_a[g] = 1'b0;
      if ((inj != 0) && (lat == inj)) begin
        spitx_a[g]   = 8'hFF;
        spitxdv_a[g] = 1'b1;
      end
      if ((inj != 0) && (lat == inj + 1)) spitxdv_a[g] = 1'b0;
      if (mosi_a[g] === 1'b1) mosi_hi = 1'b1;
    end while ((spirxdv_a[g] !== 1'b1) && (lat < 400));
    rx    = spirx_a[g];
    mo    = mosi_rx[g];
    edges = tot_edges[g] - e0;
  endtask

  task automatic check_xfer(input string tag, input int g, input logic [7:0] tx,
                            input logic [7:0] sb, input logic [7:0] exp_rx);
    int lat, edges;
    logic [7:0] rx, mo;
    logic mh;
    run_xfer(g, tx, sb, 0, lat, rx, mo, edges, mh);
    chk({tag, " rx"}, rx, exp_rx);
    chk({tag, " mosi_byte"}, mo, tx);
    chk({tag, " latency"}, lat, lat_of(g));
    chk({tag, " sclk_edges"}, edges, 16);
    chk({tag, " sclk_end"}, sclk_a[g], (g >= 2));
    @(posedge clk);
    #1;
    chk({tag, " rxdv_one_cycle"}, spirxdv_a[g], 0);
    chk({tag, " rx_held"}, spirx_a[g], exp_rx);
  endtask

  typedef struct {
    int         g;
    logic [7:0] tx;
    logic [7:0] sb;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, edges, pulses, w, e0;
    logic [7:0] rx, mo;
    logic mh;

    vecs[0] = '{0, 8'hA5, 8'h3C, 8'h3C};
    vecs[1] = '{3, 8'h81, 8'h7E, 8'h7E};
    vecs[2] = '{1, 8'h5A, 8'h96, 8'h96};
    vecs[3] = '{2, 8'h0F, 8'hF0, 8'hF0};
    vecs[4] = '{0, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{3, 8'hFF, 8'h00, 8'h00};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spitx_a[i]   = '0;
      spitxdv_a[i] = 1'b0;
      slv_byte[i]  = '0;
      mosi_rx[i]   = '0;
      tot_edges[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset ready[%0d]", i), spitxready_a[i], 1);
      chk($sformatf("reset rxdv[%0d]", i), spirxdv_a[i], 0);
      chk($sformatf("reset rx[%0d]", i), spirx_a[i], 0);
      chk($sformatf("reset sclk[%0d]", i), sclk_a[i], (i >= 2));
      chk($sformatf("reset mosi[%0d]", i), mosi_a[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      check_xfer($sformatf("vec%0d", v), vecs[v].g, vecs[v].tx, vecs[v].sb, vecs[v].exp_rx);

    // Request while busy must be dropped.
    run_xfer(0, 8'h00, 8'h5A, 5, lat, rx, mo, edges, mh);
    chk("drop mosi_stays_low", mh, 0);
    chk("drop mosi_byte", mo, 8'h00);
    chk("drop rx", rx, 8'h5A);
    chk("drop latency", lat, lat_of(0));
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (spirxdv_a[0] === 1'b1) pulses++;
    end
    chk("drop extra_rxdv", pulses, 0);
    chk("drop ready_after", spitxready_a[0], 1);

    // Back-to-back accept in the DONE cycle.
    @(negedge clk);
    slv_byte[0]  = 8'hC6;
    spitx_a[0]   = 8'hAA;
    spitxdv_a[0] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) spitxdv_a[0] = 1'b0;
    end while ((spirxdv_a[0] !== 1'b1) && (lat < 400));
    chk("b2b first latency", lat, lat_of(0));
    chk("b2b first rx", spirx_a[0], 8'hC6);
    chk("b2b first mosi", mosi_rx[0], 8'hAA);
    chk("b2b done ready", spitxready_a[0], 1);
    spitx_a[0]   = 8'h55;
    spitxdv_a[0] = 1'b1;
    slv_byte[0]  = 8'h39;
    @(posedge clk);
    #1;
    spitxdv_a[0] = 1'b0;
    chk("b2b no_idle_gap", spitxready_a[0], 0);
    lat = 1;
    while ((spirxdv_a[0] !== 1'b1) && (lat < 400)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b pulse_spacing", lat, lat_of(0));
    chk("b2b second rx", spirx_a[0], 8'h39);
    chk("b2b second mosi", mosi_rx[0], 8'h55);

    for (int r = 0; r < 12; r++) begin
      int g;
      logic [7:0] tx, sb;
      g  = int'($urandom_range(3, 0));
      tx = 8'($urandom);
      sb = 8'($urandom);
      check_xfer($sformatf("rand%0d m%0d tx%02h", r, g, tx), g, tx, sb, sb);
    end

    // Reset in the middle of a transfer (mode 3, sclk low after edge 7).
    @(negedge clk);
    while (spitxready_a[3] !== 1'b1) @(negedge clk);
    slv_byte[3]  = 8'h5A;
    spitx_a[3]   = 8'hE7;
    spitxdv_a[3] = 1'b1;
    e0 = tot_edges[3];
    @(posedge clk);
    #1;
    spitxdv_a[3] = 1'b0;
    w = 0;
    while (((tot_edges[3] - e0) < 7) && (w < 200)) begin
      @(negedge clk);
      w++;
    end
    chk("abort reached_edge7", tot_edges[3] - e0, 7);
    chk("abort sclk_before", sclk_a[3], 0);
    rst = 1'b1;
    #1;
    chk("abort sclk_cpol", sclk_a[3], 1);
    chk("abort ready", spitxready_a[3], 1);
    chk("abort rxdv", spirxdv_a[3], 0);
    chk("abort rx", spirx_a[3], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (spirxdv_a[3] === 1'b1) pulses++;
    end
    chk("abort no_rxdv", pulses, 0);
    check_xfer("abort recover", 3, 8'hC3, 8'hA5, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
